retire_buf: RTL

// - Retire buffer directly downstream of the replay pipeline's final stage. That stage never stalls,
//   so every committed beat must be absorbed here unconditionally.
// - Holds beats in a DEPTH-entry FIFO and drains them to a consumer over a valid/accept handshake.
// - Drives a registered back-pressure flag upstream, early enough that beats still in flight fit.

---
 rtl/retire_buf_pkg.sv | 35 +++
 rtl/retire_buf_if.sv | 32 +++
 rtl/retire_buf_mem.sv | 28 ++
 rtl/retire_buf.sv | 105 ++++++++++
 4 files changed

// File: rtl/retire_buf_pkg.sv
// Shared definitions for the retire buffer and the replay front-end FIFO:
// default sizing, the {wrap, index} pointer type and its compare/advance helpers.
package retire_buf_pkg;

    localparam int RB_W     = 32;
    localparam int RB_DEPTH = 16;
    localparam int RB_SKID  = 9;
    localparam int RB_AW    = $clog2(RB_DEPTH);

    // Pointer: wrap bit o plus storage index p. Sized from RB_DEPTH, so every
    // FIFO built on this type shares that depth.
    typedef struct packed {
        logic             o;
        logic [RB_AW-1:0] p;
    } ptr_t;

    // Same wrap and same index: nothing stored.
    function automatic logic ptr_empty(ptr_t rd, ptr_t wr);
        return rd == wr;
    endfunction

    // Same index but writer has lapped the reader once.
    function automatic logic ptr_full(ptr_t rd, ptr_t wr);
        return (rd.o != wr.o) && (rd.p == wr.p);
    endfunction

    // Index wraps DEPTH-1 -> 0; the carry out of the index toggles the wrap bit.
    function automatic ptr_t ptr_inc(ptr_t x);
        logic [RB_AW:0] v;
        v = x;
        v = v + 1'b1;
        return ptr_t'(v);
    endfunction

endpackage

// File: rtl/retire_buf_if.sv
// Retire buffer bus: pipeline-side beat input with back-pressure, consumer-side
// valid/accept head, plus occupancy and sticky overflow status.
interface retire_buf_if
    import retire_buf_pkg::*;
#(
    parameter int W     = RB_W,
    parameter int DEPTH = RB_DEPTH
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [W-1:0]  in;
    logic          in_vld;
    logic          stall_r;
    logic [W-1:0]  out_r;
    logic          out_vld_r;
    logic          out_accept;
    logic [LW-1:0] level_r;
    logic          overflow_r;

    // Environment side: drives beats and accepts, observes status.
    modport master (
        output in, in_vld, out_accept,
        input  stall_r, out_r, out_vld_r, level_r, overflow_r
    );

    // Buffer side.
    modport slave (
        input  in, in_vld, out_accept,
        output stall_r, out_r, out_vld_r, level_r, overflow_r
    );

endinterface

// File: rtl/retire_buf_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
module retire_buf_mem #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write the addressed entry on a push.
    // NOTE: storage has no reset; the pointers define which entries are valid,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/retire_buf.sv
// Retire buffer behind the non-stalling replay pipeline's final stage.
// Every beat is absorbed into a FIFO and drained through a registered head over
// valid/accept; stall_r is raised early enough that SKID in-flight beats still fit.
module retire_buf
    import retire_buf_pkg::*;
#(
    parameter int W     = RB_W,
    parameter int DEPTH = RB_DEPTH,
    parameter int SKID  = RB_SKID
) (
    input  logic         clk,
    input  logic         rst_n,
    retire_buf_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] STALL_AT = LW'(DEPTH - SKID);

    // The pointer type is sized by the package, so the depth must match it.
    if (DEPTH != RB_DEPTH) begin : g_depth_check
        $error("retire_buf: DEPTH must equal retire_buf_pkg::RB_DEPTH");
    end
    if (SKID >= DEPTH) begin : g_skid_check
        $error("retire_buf: SKID must be smaller than DEPTH");
    end

    ptr_t          rd_q, wr_q;
    ptr_t          rd_d, wr_d;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovf_evt;
    logic          head_load;
    logic          vld_d;
    logic [LW-1:0] level_d;
    logic [W-1:0]  head_d;
    logic [W-1:0]  mem_rdata;

    // Handshake decode, pointer/level next values and the next head entry.
    // NOTE: every output of this block is assigned on every pass, so no latch
    // can be inferred.
    always_comb begin
        pop     = bus.out_vld_r & bus.out_accept;
        full    = ptr_full(rd_q, wr_q);
        push    = bus.in_vld & (~full | pop);
        ovf_evt = bus.in_vld & full & ~pop;

        wr_d    = push ? ptr_inc(wr_q) : wr_q;
        rd_d    = pop  ? ptr_inc(rd_q) : rd_q;
        level_d = bus.level_r + LW'(push) - LW'(pop);

        // The head is reloaded whenever it is consumed or currently empty.
        head_load = pop | ~bus.out_vld_r;
        vld_d     = ~ptr_empty(rd_d, wr_d);
        // If the next head slot is the one being written this cycle, bypass the
        // array so an empty (or single-entry, popping) FIFO shows no bubble.
        head_d    = (push && (rd_d == wr_q)) ? bus.in : mem_rdata;
    end

    retire_buf_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_q.p),
        .wdata (bus.in),
        .raddr (rd_d.p),
        .rdata (mem_rdata)
    );

    // Pointers, occupancy, back-pressure and sticky overflow.
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q           <= '0;
            wr_q           <= '0;
            bus.level_r    <= '0;
            bus.stall_r    <= 1'b0;
            bus.overflow_r <= 1'b0;
        end else begin
            rd_q           <= rd_d;
            wr_q           <= wr_d;
            bus.level_r    <= level_d;
            bus.stall_r    <= (level_d >= STALL_AT);
            bus.overflow_r <= bus.overflow_r | ovf_evt;
        end
    end

    // Registered head: load on pop or when empty, otherwise hold stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_vld_r <= 1'b0;
            bus.out_r     <= '0;
        end else if (head_load) begin
            bus.out_vld_r <= vld_d;
            if (vld_d) begin
                bus.out_r <= head_d;
            end
        end
    end

endmodule
